// File: rtl/elevator_req_queue.sv
// ============================================================================
// Module  : elevator_req_queue
// Brief   : De-duplicating FWFT floor-request queue with per-floor pending lamps.
//           Optional drop counter enabled by defining ELEV_REQ_DROP_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module elevator_req_queue #(
   parameter int DEPTH      = 8,
   parameter int NUM_FLOORS = 16,
   parameter int FLOOR_W    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   input  logic [FLOOR_W-1:0]       req_floor,
   output logic                     req_accept,
   output logic                     req_drop,
   output logic                     fifo_empty,
   output logic [FLOOR_W-1:0]       fifo_dout,
   input  logic                     fifo_rd,
   output logic [$clog2(DEPTH):0]   count,
`ifdef ELEV_REQ_DROP_CNT_EN
   input  logic                     drop_clr,
   output logic [7:0]               drop_cnt,
`endif
   output logic [NUM_FLOORS-1:0]    pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FLOOR_W-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  accept_q, drop_q;

   logic                  w_in_range;
   logic                  w_dup;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [NUM_FLOORS-1:0] w_req_oh;
   logic [NUM_FLOORS-1:0] w_pop_oh;

   // Duplicate check uses the pre-update pending bits, so re-requesting the
   // floor being popped this cycle is dropped and its lamp goes dark.
   always_comb begin
      w_in_range = ({1'b0, req_floor} < (FLOOR_W+1)'(NUM_FLOORS));
      w_req_oh   = w_in_range ? (NUM_FLOORS'(1) << req_floor) : '0;
      w_pop_oh   = NUM_FLOORS'(1) << fifo_dout;
      w_dup      = |(pending_q & w_req_oh);
      w_full     = (count_q == CNT_W'(DEPTH));
      w_pop      = fifo_rd && (count_q != '0);
      w_push     = req_valid && w_in_range && !w_dup && (!w_full || w_pop);
      w_drop     = req_valid && !w_push;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pending_d  = pending_q;
      count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         pending_d = pending_d & ~w_pop_oh;
      end
      if (w_push) begin
         wr_ptr_d  = wr_ptr_q + 1'b1;
         pending_d = pending_d | w_req_oh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= '0;
         accept_q  <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         accept_q  <= w_push;
         drop_q    <= w_drop;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= req_floor;
      end
   end

`ifdef ELEV_REQ_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else if (drop_clr) begin
         drop_cnt_q <= '0;
      end else if (w_drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   assign fifo_dout  = mem_q[rd_ptr_q];
   assign fifo_empty = (count_q == '0);
   assign count      = count_q;
   assign pending    = pending_q;
   assign req_accept = accept_q;
   assign req_drop   = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_req_queue.sv
// ============================================================================
// Module  : tb_elevator_req_queue
// Brief   : Directed vector table plus randomized run against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_elevator_req_queue;

   localparam int DEPTH      = 8;
   localparam int NUM_FLOORS = 16;
   localparam int FLOOR_W    = 5;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  req_valid;
   logic [FLOOR_W-1:0]    req_floor;
   logic                  req_accept;
   logic                  req_drop;
   logic                  fifo_empty;
   logic [FLOOR_W-1:0]    fifo_dout;
   logic                  fifo_rd;
   logic [3:0]            count;
   logic [NUM_FLOORS-1:0] pending;
`ifdef ELEV_REQ_DROP_CNT_EN
   logic                  drop_clr;
   logic [7:0]            drop_cnt;
`endif

   elevator_req_queue #(
      .DEPTH      (DEPTH),
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_floor  (req_floor),
      .req_accept (req_accept),
      .req_drop   (req_drop),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .count      (count),
`ifdef ELEV_REQ_DROP_CNT_EN
      .drop_clr   (drop_clr),
      .drop_cnt   (drop_cnt),
`endif
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: arrival-ordered list of queued floors.
   int   m_q[$];
   logic m_acc;
   logic m_drop;
   int   m_dcnt;

   typedef struct {
      logic        v;
      logic [4:0]  f;
      logic        rd;
      logic        acc;
      logic        drp;
      logic [3:0]  cnt;
      logic        emp;
      logic [4:0]  dout;
      logic [15:0] pend;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] model_pending();
      logic [15:0] p = '0;
      foreach (m_q[i]) p[m_q[i]] = 1'b1;
      return p;
   endfunction

   task automatic step(input logic v, input logic [4:0] f, input logic rd);
      logic popped;
      logic dup;
      req_valid = v;
      req_floor = f;
      fifo_rd   = rd;
      popped = rd && (m_q.size() > 0);
      dup    = 1'b0;
      foreach (m_q[i]) if (m_q[i] == int'(f)) dup = 1'b1;
      m_acc  = v && (f < 5'(NUM_FLOORS)) && !dup && ((m_q.size() < DEPTH) || popped);
      m_drop = v && !m_acc;
      if (popped) void'(m_q.pop_front());
      if (m_acc) m_q.push_back(int'(f));
`ifdef ELEV_REQ_DROP_CNT_EN
      if (drop_clr) m_dcnt = 0;
      else if (m_drop && m_dcnt < 255) m_dcnt++;
`endif
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      fifo_rd   = 1'b0;
`ifdef ELEV_REQ_DROP_CNT_EN
      drop_clr  = 1'b0;
`endif
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".accept"},  32'(req_accept), 32'(m_acc));
      chk({tag, ".drop"},    32'(req_drop),   32'(m_drop));
      chk({tag, ".count"},   32'(count),      32'(m_q.size()));
      chk({tag, ".empty"},   32'(fifo_empty), 32'(m_q.size() == 0));
      chk({tag, ".pending"}, 32'(pending),    32'(model_pending()));
      if (m_q.size() > 0) chk({tag, ".dout"}, 32'(fifo_dout), 32'(m_q[0]));
`ifdef ELEV_REQ_DROP_CNT_EN
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_dcnt));
`endif
   endtask

   task automatic add(input logic v, input logic [4:0] f, input logic rd, input logic acc,
                      input logic drp, input logic [3:0] cnt, input logic emp,
                      input logic [4:0] dout, input logic [15:0] pend);
      tbl.push_back('{v, f, rd, acc, drp, cnt, emp, dout, pend});
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_floor = '0;
      fifo_rd   = 1'b0;
      m_dcnt    = 0;
`ifdef ELEV_REQ_DROP_CNT_EN
      drop_clr  = 1'b0;
`endif

      // Ordering: 5, 2, 9 with reads once non-empty
      add(1, 5, 0, 1, 0, 1, 0, 5, 16'h0020);
      add(1, 2, 1, 1, 0, 1, 0, 2, 16'h0004);
      add(1, 9, 1, 1, 0, 1, 0, 9, 16'h0200);
      add(0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
      // Duplicate and out-of-range
      add(1, 3, 0, 1, 0, 1, 0, 3, 16'h0008);
      add(1, 3, 0, 0, 1, 1, 0, 3, 16'h0008);
      add(1, 16, 0, 0, 1, 1, 0, 3, 16'h0008);
      add(0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
      // Fill to full, overflow drop, then push-with-pop while full
      for (int i = 0; i < 8; i++)
         add(1, 5'(i), 0, 1, 0, 4'(i + 1), 0, 0, 16'((1 << (i + 1)) - 1));
      add(1, 8, 0, 0, 1, 8, 0, 0, 16'h00FF);
      add(1, 9, 1, 1, 0, 8, 0, 1, 16'h02FE);
      // Drain
      add(0, 0, 1, 0, 0, 7, 0, 2, 16'h02FC);
      add(0, 0, 1, 0, 0, 6, 0, 3, 16'h02F8);
      add(0, 0, 1, 0, 0, 5, 0, 4, 16'h02F0);
      add(0, 0, 1, 0, 0, 4, 0, 5, 16'h02E0);
      add(0, 0, 1, 0, 0, 3, 0, 6, 16'h02C0);
      add(0, 0, 1, 0, 0, 2, 0, 7, 16'h0280);
      add(0, 0, 1, 0, 0, 1, 0, 9, 16'h0200);
      add(0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
      // Same-floor collision between push and pop
      add(1, 4, 0, 1, 0, 1, 0, 4, 16'h0010);
      add(1, 4, 1, 0, 1, 0, 1, 0, 16'h0000);
      // Read while empty is ignored
      add(0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);

      repeat (2) @(posedge clk);
      #1;
      chk("rst.empty",   32'(fifo_empty), 32'd1);
      chk("rst.count",   32'(count),      32'd0);
      chk("rst.pending", 32'(pending),    32'd0);
      chk("rst.accept",  32'(req_accept), 32'd0);
      chk("rst.drop",    32'(req_drop),   32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle.count", 32'(count), 32'd0);

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].f, tbl[i].rd);
         chk($sformatf("vec%0d.accept", i),  32'(req_accept), 32'(tbl[i].acc));
         chk($sformatf("vec%0d.drop", i),    32'(req_drop),   32'(tbl[i].drp));
         chk($sformatf("vec%0d.count", i),   32'(count),      32'(tbl[i].cnt));
         chk($sformatf("vec%0d.empty", i),   32'(fifo_empty), 32'(tbl[i].emp));
         chk($sformatf("vec%0d.pending", i), 32'(pending),    32'(tbl[i].pend));
         if (!tbl[i].emp) chk($sformatf("vec%0d.dout", i), 32'(fifo_dout), 32'(tbl[i].dout));
      end

      // Asynchronous reset mid-stream with five queued requests
      for (int i = 0; i < 5; i++) step(1, 5'(10 + i), 0);
      check_model("pre_arst");
      #3 rst_n = 1'b0;
      #1;
      chk("arst.count",   32'(count),      32'd0);
      chk("arst.empty",   32'(fifo_empty), 32'd1);
      chk("arst.pending", 32'(pending),    32'd0);
      m_q.delete();
      m_acc  = 1'b0;
      m_drop = 1'b0;
      m_dcnt = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_model("post_arst");

      for (int c = 0; c < 3000; c++) begin
         step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 17)),
              ($urandom_range(0, 2) == 0));
         check_model("rand");
      end

`ifdef ELEV_REQ_DROP_CNT_EN
      for (int i = 0; i < 300; i++) begin
         step(1, 5'd20, 0);
         check_model("dcnt");
      end
      chk("dcnt.sat", 32'(drop_cnt), 32'd255);
      drop_clr = 1'b1;
      step(1, 5'd20, 0);
      chk("dcnt.clr", 32'(drop_cnt), 32'd0);
      check_model("dcnt_clr");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
